// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store initiator.
// State encoding, access-size codes and byte-count helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    unique case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: big-endian lane extract/extend for loads and
// lane merge for sub-word stores (combinational).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sext,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  bl;
  logic [15:0] hl;

  // Byte 0 of a word sits in the top lane, so shift by 3-off lanes.
  assign bsh = {~off, 3'b000};
  assign hsh = {~off[1], 4'b0000};
  assign bl  = 8'(rdata >> bsh);
  assign hl  = 16'(rdata >> hsh);

  always_comb begin
    ldata = rdata;
    mdata = wdata;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        ldata = {{24{sext & bl[7]}}, bl};
        mdata = (rdata & ~(32'h0000_00ff << bsh))
              | ({24'b0, wdata[7:0]} << bsh);
      end
      (size == SZ_HALF): begin
        ldata = {{16{sext & hl[15]}}, hl};
        mdata = (rdata & ~(32'h0000_ffff << hsh))
              | ({16'b0, wdata[15:0]} << hsh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: one-at-a-time load/store initiator for data_memory.
// Define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_MemWrite,
  input  logic [31:0] mem_readData
);

  state_t      state;
  logic        r_write;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] ldata;
  logic [31:0] mdata;
  logic [32:0] end_addr;
  logic        range_err;
  logic        size_err;
  logic        align_err;
  logic        req_err;
  logic [31:0] word_addr;
  logic [31:0] wr_addr;

  assign end_addr  = {1'b0, req_addr} + {30'b0, size_bytes(req_size)};
  assign range_err = end_addr > 33'(MEM_BYTES);
  assign size_err  = req_size == 2'b11;
`ifdef LSU_ALIGN_CHECK_EN
  assign align_err = (req_size == SZ_HALF && req_addr[0])
                   | (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  assign wr_addr   = r_addr;
`else
  assign align_err = 1'b0;
  assign wr_addr   = word_addr;
`endif
  assign req_err   = range_err | size_err | align_err;
  assign word_addr = {r_addr[31:2], 2'b00};

  lsu_lane_align u_align (
    .size  (r_size),
    .off   (r_addr[1:0]),
    .sext  (r_signed),
    .rdata (mem_readData),
    .wdata (r_data),
    .ldata (ldata),
    .mdata (mdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      r_write    <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_data     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          r_write  <= req_write;
          r_signed <= req_signed;
          r_size   <= req_size;
          r_addr   <= req_addr;
          r_data   <= req_wdata;
          if (req_err) begin
            resp_err <= 1'b1;
            state    <= S_RESP;
          end else if (req_write && req_size == SZ_WORD) begin
            state <= S_WRITE;
          end else begin
            state <= S_READ;
          end
        end
        S_READ:  state <= S_LATCH;
        S_LATCH: if (r_write) begin
          r_data <= mdata;
          state  <= S_WRITE;
        end else begin
          resp_rdata <= ldata;
          state      <= S_RESP;
        end
        S_WRITE: state <= S_RESP;
        S_RESP: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_address   = '0;
    mem_writeData = '0;
    unique case (state)
      S_READ, S_LATCH: mem_address = word_addr;
      S_WRITE: begin
        mem_address   = (r_size == SZ_WORD) ? wr_addr : word_addr;
        mem_writeData = r_data;
      end
      default: ;
    endcase
  end

  assign req_ready    = (state == S_IDLE) && !rst;
  assign resp_valid   = (state == S_RESP) && !rst;
  assign mem_MemWrite = (state == S_WRITE) && !rst;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed + random checks against a byte-array model.
// Honours LSU_ALIGN_CHECK_EN in the same way as the design.
module tb_lsu_mem_master;

  localparam int MEM_BYTES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_MemWrite;
  logic [31:0] mem_readData;

  logic [7:0]  dmem   [MEM_BYTES];
  logic [7:0]  refmem [MEM_BYTES];

  int tests  = 0;
  int failed = 0;

  lsu_mem_master #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_writeData(mem_writeData),
    .mem_MemWrite (mem_MemWrite),
    .mem_readData (mem_readData)
  );

  always #5 clk = ~clk;

  // data_memory stand-in: big-endian, registered read, full-word write
  always @(posedge clk) begin
    if (mem_MemWrite)
      for (int i = 0; i < 4; i++)
        dmem[{mem_address[3:2], 2'(i)}] <= mem_writeData[31-8*i -: 8];
    mem_readData <= {dmem[{mem_address[3:2], 2'd0}],
                     dmem[{mem_address[3:2], 2'd1}],
                     dmem[{mem_address[3:2], 2'd2}],
                     dmem[{mem_address[3:2], 2'd3}]};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: bytes, sizes and latencies from the access rules.
  task automatic ref_exec(input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, output logic err,
                          output logic [31:0] rd, output int lat,
                          output int nw, output int wc);
    int nb;
    int ea;
    logic [31:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (({1'b0, a} + 33'(nb)) > 33'(MEM_BYTES));
`ifdef LSU_ALIGN_CHECK_EN
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) err = 1'b1;
`endif
    rd = '0; nw = 0; wc = 0; lat = 1;
    if (!err) begin
      ea = int'(a) - (int'(a) % nb);
      if (w) begin
        for (int i = 0; i < nb; i++)
          refmem[ea+i] = 8'(wd >> (8 * (nb - 1 - i)));
        nw  = 1;
        lat = (nb == 4) ? 2 : 4;
        wc  = lat - 1;
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(refmem[ea+i]);
        if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rd  = v;
        lat = 3;
      end
    end
  endtask

  // Caller is at a negedge. exp_wait < 0 skips the acceptance-wait check.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_wait,
                        output logic [31:0] obs);
    logic e_err;
    logic [31:0] e_rd;
    int e_lat, e_nw, e_wc;
    int waited, n, writes, wcyc;
    bit got;
    ref_exec(w, sz, sg, a, wd, e_err, e_rd, e_lat, e_nw, e_wc);
    req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    if (exp_wait >= 0) chk({tag, "_wait"}, waited, exp_wait);
    @(posedge clk);
    got = 0; n = 0; writes = 0; wcyc = 0; obs = '0;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      if (n == 1) req_valid = 1'b0;
      if (mem_MemWrite) begin writes++; wcyc = n; end
      if (resp_valid) begin got = 1; obs = resp_rdata; end
    end
    chk({tag, "_lat"}, n, got ? e_lat : -1);
    chk({tag, "_err"}, 32'(resp_err), 32'(e_err));
    chk({tag, "_rdata"}, resp_rdata, e_rd);
    chk({tag, "_nwr"}, writes, e_nw);
    if (e_nw != 0) chk({tag, "_wcyc"}, wcyc, e_wc);
  endtask

  initial begin
    logic [31:0] r;
    bit seen;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      dmem[i]   = (i == 0) ? 8'h80 : 8'(8'h11 * i);
      refmem[i] = dmem[i];
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_writeData, 32'd0);
    chk("rst_we", 32'(mem_MemWrite), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    do_req("lw0", 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 0, r);
    chk("plan_lw0", r, 32'h8011_2233);
    do_req("lbs0", 1'b0, 2'd0, 1'b1, 32'd0, 32'd0, -1, r);
    chk("plan_lbs0", r, 32'hFFFF_FF80);
    do_req("lbu0", 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, -1, r);
    chk("plan_lbu0", r, 32'h0000_0080);
    do_req("lhs2", 1'b0, 2'd1, 1'b1, 32'd2, 32'd0, -1, r);
    chk("plan_lhs2", r, 32'h0000_2233);
    do_req("sb1", 1'b1, 2'd0, 1'b0, 32'd1, 32'h1234_56AB, -1, r);
    do_req("lw0b", 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, -1, r);
    chk("plan_merge", r, 32'h80AB_2233);
    do_req("lh1", 1'b0, 2'd1, 1'b0, 32'd1, 32'd0, -1, r);
`ifdef LSU_ALIGN_CHECK_EN
    chk("plan_lh1", r, 32'h0000_0000);
`else
    chk("plan_lh1", r, 32'h0000_80AB);
`endif
    do_req("lw14", 1'b0, 2'd2, 1'b0, 32'd14, 32'd0, -1, r);
    do_req("sw14", 1'b1, 2'd2, 1'b0, 32'd14, 32'hDEAD_BEEF, -1, r);
    do_req("rsv", 1'b1, 2'd3, 1'b0, 32'd0, 32'hFFFF_FFFF, -1, r);

    // byte store to addr 5 cut short by reset in LATCH
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd5; req_wdata = 32'h0000_00C3; req_valid = 1'b1;
    seen = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen |= resp_valid;
    @(negedge clk);
    rst = 1'b1;
    #1;
    seen |= resp_valid;
    chk("rstmid_we", 32'(mem_MemWrite), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    seen |= resp_valid | mem_MemWrite;
    rst = 1'b0;
    @(negedge clk);
    seen |= resp_valid | mem_MemWrite;
    chk("rstmid_ready_after", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      seen |= resp_valid | mem_MemWrite;
    end
    chk("rstmid_quiet", 32'(seen), 32'd0);
    chk("rstmid_mem5", 32'(dmem[5]), 32'(refmem[5]));

    do_req("b2b_a", 1'b0, 2'd2, 1'b0, 32'd4, 32'd0, -1, r);
    do_req("b2b_b", 1'b0, 2'd0, 1'b1, 32'd8, 32'd0, 1, r);
    do_req("b2b_c", 1'b1, 2'd1, 1'b0, 32'd10, 32'h0000_9A7E, 1, r);

    for (int k = 0; k < 48; k++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd0;
      do_req($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), sz,
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 17)),
             $urandom, -1, r);
    end

    for (int i = 0; i < MEM_BYTES; i++)
      chk($sformatf("final_mem%0d", i), 32'(dmem[i]), 32'(refmem[i]));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
